cic_rate_ctrl: RTL and testbench

Run-time controller for the CIC decimator chain. It owns the decimation rate and sequences every rate change: accept the new rate, clear the CIC datapath, then discard the comb transient before passing samples on. It sits between the sample source / host config port and the CIC integrator, decimator and comb stages. It generates the decimation strobe and gates the CIC output-valid.

---
 rtl/cic_ctrl_pkg.sv | 20 ++
 rtl/cic_dec_counter.sv | 27 ++
 rtl/cic_rate_ctrl.sv | 114 +++++++++++
 tb/tb_cic_rate_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cic_ctrl_pkg.sv
// Shared types and helpers for the CIC rate controller.
// Provides the FSM state enum, the minimum legal rate and the rate clamp.
package cic_ctrl_pkg;

   typedef enum logic [1:0] {
      CLEAR  = 2'd0,
      SETTLE = 2'd1,
      RUN    = 2'd2
   } state_t;

   localparam int R_MIN = 2;

   // Rates below R_MIN would never produce a strobe period the comb can use.
   function automatic logic [31:0] clamp_rate(input logic [31:0] r);
      if (r < 32'(R_MIN))
         return 32'(R_MIN);
      return r;
   endfunction

endpackage

// File: rtl/cic_dec_counter.sv
// Wrap-at-rate decimation counter producing a one-cycle strobe.
// Ports: clk, reset, clear (sync zero), ce (count enable), rate, strobe.
module cic_dec_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clear,
   input  logic         ce,
   input  logic [W-1:0] rate,
   output logic         strobe
);

   logic [W-1:0] cnt;
   logic         last;

   assign last   = (cnt == rate - W'(1));
   assign strobe = ce && last;

   always_ff @(posedge clk) begin
      if (reset || clear)
         cnt <= '0;
      else if (ce)
         cnt <= last ? '0 : cnt + W'(1);
   end

endmodule

// File: rtl/cic_rate_ctrl.sv
// Run-time rate controller for the CIC decimator: owns the rate, clears
// the chain on change, discards the comb transient, gates strobes/valids.
// Ports: i_clk/i_reset, i_ce sample strobe, i_cfg_valid/i_cfg_rate/
// o_cfg_ready config handshake, o_cic_clear/o_cic_ce/o_dec_strobe to the
// CIC stages, i_cic_ready -> o_out_valid, o_rate and o_busy status.
module cic_rate_ctrl
   import cic_ctrl_pkg::*;
#(
   parameter int RW         = 16,
   parameter int M          = 10,
   parameter int R_DEFAULT  = 100,
   parameter int CLR_CYCLES = 12
) (
   input  logic          i_clk,
   input  logic          i_reset,
   input  logic          i_ce,
   input  logic          i_cfg_valid,
   input  logic [RW-1:0] i_cfg_rate,
   output logic          o_cfg_ready,
   output logic          o_cic_clear,
   output logic          o_cic_ce,
   output logic          o_dec_strobe,
   input  logic          i_cic_ready,
   output logic          o_out_valid,
   output logic [RW-1:0] o_rate,
   output logic          o_busy
);

   localparam int CW = $clog2(CLR_CYCLES + 1);
   localparam int DW = $clog2(M + 1);

   state_t        state;
   state_t        state_d;
   logic [CW-1:0] clr_cnt;
   logic [CW-1:0] clr_d;
   logic [DW-1:0] disc_cnt;
   logic [DW-1:0] disc_d;
   logic [RW-1:0] rate_q;
   logic [RW-1:0] rate_d;
   logic          run_ce;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state    <= CLEAR;
         clr_cnt  <= '0;
         disc_cnt <= '0;
         rate_q   <= RW'(R_DEFAULT);
      end else begin
         state    <= state_d;
         clr_cnt  <= clr_d;
         disc_cnt <= disc_d;
         rate_q   <= rate_d;
      end
   end

   always_comb begin
      state_d     = state;
      clr_d       = clr_cnt;
      disc_d      = disc_cnt;
      rate_d      = rate_q;
      o_cic_clear = 1'b0;
      o_cfg_ready = 1'b0;
      o_out_valid = 1'b0;
      run_ce      = 1'b0;
      unique case (state)
         CLEAR: begin
            o_cic_clear = 1'b1;
            clr_d       = clr_cnt + CW'(1);
            if (clr_cnt == CW'(CLR_CYCLES - 1)) begin
               state_d = SETTLE;
               clr_d   = '0;
               disc_d  = '0;
            end
         end
         SETTLE: begin
            run_ce = i_ce;
            // The M-th comb output is the last transient one; drop it too.
            if (i_cic_ready) begin
               disc_d = disc_cnt + DW'(1);
               if (disc_cnt == DW'(M - 1))
                  state_d = RUN;
            end
         end
         RUN: begin
            run_ce      = i_ce;
            o_cfg_ready = 1'b1;
            o_out_valid = i_cic_ready;
            if (i_cfg_valid) begin
               rate_d  = RW'(clamp_rate(32'(i_cfg_rate)));
               clr_d   = '0;
               state_d = CLEAR;
            end
         end
         default: state_d = CLEAR;
      endcase
   end

   // Counter is held at zero for the whole clear, so SETTLE starts at 0.
   cic_dec_counter #(
      .W (RW)
   ) u_dec_cnt (
      .clk    (i_clk),
      .reset  (i_reset),
      .clear  (state == CLEAR),
      .ce     (run_ce),
      .rate   (rate_q),
      .strobe (o_dec_strobe)
   );

   assign o_cic_ce = run_ce;
   assign o_rate   = rate_q;
   assign o_busy   = (state != RUN);

endmodule

// File: tb/tb_cic_rate_ctrl.sv
// Directed self-checking bench for cic_rate_ctrl.
// Walks reset, settle, strobe spacing, rate change, clamp and reset abort.
module tb_cic_rate_ctrl;

   localparam int RW = 16;
   localparam int M  = 10;

   logic          clk = 1'b0;
   logic          i_reset;
   logic          i_ce;
   logic          i_cfg_valid;
   logic [RW-1:0] i_cfg_rate;
   logic          o_cfg_ready;
   logic          o_cic_clear;
   logic          o_cic_ce;
   logic          o_dec_strobe;
   logic          i_cic_ready;
   logic          o_out_valid;
   logic [RW-1:0] o_rate;
   logic          o_busy;

   int total = 0;
   int bad   = 0;

   cic_rate_ctrl #(
      .RW         (RW),
      .M          (M),
      .R_DEFAULT  (100),
      .CLR_CYCLES (12)
   ) dut (
      .i_clk        (clk),
      .i_reset      (i_reset),
      .i_ce         (i_ce),
      .i_cfg_valid  (i_cfg_valid),
      .i_cfg_rate   (i_cfg_rate),
      .o_cfg_ready  (o_cfg_ready),
      .o_cic_clear  (o_cic_clear),
      .o_cic_ce     (o_cic_ce),
      .o_dec_strobe (o_dec_strobe),
      .i_cic_ready  (i_cic_ready),
      .o_out_valid  (o_out_valid),
      .o_rate       (o_rate),
      .o_busy       (o_busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s: got=%0d want=%0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic count_clear(output int n);
      n = 0;
      repeat (20) begin
         #2;
         if (o_cic_clear) n++;
         tick();
      end
   endtask

   task automatic run_settle(input int r, input string tag);
      int ces;
      int pulses;
      int first;
      int last;
      int gap;
      ces    = 0;
      pulses = 0;
      first  = -1;
      last   = 0;
      gap    = 0;
      i_ce   = 1'b1;
      for (int k = 0; k < (M + 2) * r + 20 && pulses < M + 1; k++) begin
         i_cic_ready = 1'b0;
         #1;
         ces++;
         if (o_dec_strobe) begin
            pulses++;
            if (first < 0) first = ces;
            if (pulses == 3) gap = ces - last;
            last = ces;
            i_cic_ready = 1'b1;
            #1;
            if (pulses <= M) begin
               chk({tag, "_disc_valid"}, o_out_valid, 0);
               if (pulses == M) chk({tag, "_disc_busy"}, o_busy, 1);
            end else begin
               chk({tag, "_pass_valid"}, o_out_valid, 1);
               chk({tag, "_pass_busy"}, o_busy, 0);
            end
         end
         tick();
      end
      i_ce        = 1'b0;
      i_cic_ready = 1'b0;
      chk({tag, "_first_strobe"}, first, r);
      chk({tag, "_strobe_gap"}, gap, r);
      chk({tag, "_pulses"}, pulses, M + 1);
   endtask

   initial begin
      int n;
      int s;
      int first;
      int second;
      int p;

      // reset with all inputs active to prove gating
      i_reset     = 1'b1;
      i_ce        = 1'b1;
      i_cic_ready = 1'b1;
      i_cfg_valid = 1'b1;
      i_cfg_rate  = 16'd5;
      @(posedge clk);
      #1;
      tick();
      tick();
      #1;
      chk("rst_clear", o_cic_clear, 1);
      chk("rst_busy", o_busy, 1);
      chk("rst_rate", o_rate, 100);
      chk("rst_cic_ce", o_cic_ce, 0);
      chk("rst_strobe", o_dec_strobe, 0);
      chk("rst_valid", o_out_valid, 0);
      chk("rst_ready", o_cfg_ready, 0);
      tick();
      i_reset     = 1'b0;
      i_ce        = 1'b0;
      i_cic_ready = 1'b0;
      i_cfg_valid = 1'b0;
      #1;
      chk("clr_rate", o_rate, 100);
      chk("clr_busy", o_busy, 1);
      #1;
      count_clear(n);
      chk("clr_len", n, 12);
      chk("settle_clear", o_cic_clear, 0);
      chk("settle_busy", o_busy, 1);

      run_settle(100, "r100");

      // strobe spacing: i_ce every 3rd cycle at rate 100
      s      = 0;
      first  = -1;
      second = -1;
      for (int k = 0; k < 700; k++) begin
         i_ce = (k % 3 == 0);
         #1;
         if (o_dec_strobe) begin
            s++;
            chk("space_coincide", i_ce, 1);
            if (s == 1) first = k;
            if (s == 2) second = k;
         end
         tick();
      end
      i_ce = 1'b0;
      chk("space_first", first, 297);
      chk("space_gap", second - first, 300);
      chk("space_count", s, 2);

      // rate change to 8
      i_cfg_valid = 1'b1;
      i_cfg_rate  = 16'd8;
      #1;
      chk("chg_ready", o_cfg_ready, 1);
      tick();
      i_cfg_valid = 1'b0;
      #1;
      chk("chg_rate", o_rate, 8);
      chk("chg_busy", o_busy, 1);
      count_clear(n);
      chk("chg_clr_len", n, 12);
      run_settle(8, "r8");

      // clamp 0 -> 2, then a held request for 50 is ignored
      i_cfg_valid = 1'b1;
      i_cfg_rate  = 16'd0;
      #1;
      chk("clamp_ready", o_cfg_ready, 1);
      tick();
      i_cfg_rate = 16'd50;
      #1;
      chk("clamp_rate", o_rate, 2);
      chk("ign_ready_clr", o_cfg_ready, 0);
      repeat (19) tick();
      #1;
      chk("ign_rate", o_rate, 2);
      chk("ign_busy", o_busy, 1);
      chk("ign_ready_settle", o_cfg_ready, 0);
      i_cfg_valid = 1'b0;
      run_settle(2, "r2");
      chk("r2_rate", o_rate, 2);

      // mid-settle reset after 4 discards
      i_cfg_valid = 1'b1;
      i_cfg_rate  = 16'd8;
      tick();
      i_cfg_valid = 1'b0;
      repeat (12) tick();
      p    = 0;
      i_ce = 1'b1;
      for (int k = 0; k < 100 && p < 4; k++) begin
         i_cic_ready = 1'b0;
         #1;
         if (o_dec_strobe) begin
            p++;
            i_cic_ready = 1'b1;
         end
         tick();
      end
      i_ce        = 1'b0;
      i_cic_ready = 1'b0;
      chk("mid_disc4", p, 4);
      chk("mid_busy", o_busy, 1);
      i_reset = 1'b1;
      tick();
      i_reset = 1'b0;
      #1;
      chk("mid_clear", o_cic_clear, 1);
      chk("mid_rate", o_rate, 100);
      chk("mid_busy2", o_busy, 1);
      #1;
      count_clear(n);
      chk("mid_clr_len", n, 12);
      run_settle(100, "mid");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
